// File: rtl/uart_mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_mem_bridge                                                     |
// | Brief  : UART frame command bridge to a single-port request/grant memory.    |
// | Rev    : 1.0 - initial release                                               |
// +----------------------------------------------------------------------------+
module uart_mem_bridge #(
    parameter int FRAME_WIDTH    = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   rx_valid,
    input  logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   rx_ready,
    output logic                   tx_valid,
    output logic [FRAME_WIDTH-1:0] tx_data,
    input  logic                   tx_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int c_AF   = (ADDR_WIDTH + FRAME_WIDTH - 1) / FRAME_WIDTH;
    localparam int c_DF   = (DATA_WIDTH + FRAME_WIDTH - 1) / FRAME_WIDTH;
    localparam int c_AW   = c_AF * FRAME_WIDTH;
    localparam int c_DW   = c_DF * FRAME_WIDTH;
    localparam int c_LW   = FRAME_WIDTH - 1;
    localparam int c_FMAX = (c_AF > c_DF) ? c_AF : c_DF;
    localparam int c_FCW  = (c_FMAX > 1) ? $clog2(c_FMAX) : 1;
    localparam int c_TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_FCW-1:0] c_AF_LAST = c_FCW'(c_AF - 1);
    localparam logic [c_FCW-1:0] c_DF_LAST = c_FCW'(c_DF - 1);
    localparam logic [c_TW-1:0]  c_TLIM    = c_TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic             c_TEN     = (TIMEOUT_CYCLES > 0);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ADDR  = 3'd1;
    localparam logic [2:0] c_WDATA = 3'd2;
    localparam logic [2:0] c_WREQ  = 3'd3;
    localparam logic [2:0] c_ACK   = 3'd4;
    localparam logic [2:0] c_RREQ  = 3'd5;
    localparam logic [2:0] c_RWAIT = 3'd6;
    localparam logic [2:0] c_RSEND = 3'd7;

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [FRAME_WIDTH-1:0] r_cmd;
    logic [c_LW-1:0]        r_remain;
    logic [c_AW-1:0]        r_addr;
    logic [c_DW-1:0]        r_word;
    logic [c_FCW-1:0]       r_fcnt;
    logic [c_TW-1:0]        r_tcnt;
    logic                   r_err;

    logic w_rx_hs;
    logic w_tx_hs;
    logic w_in_rx;
    logic w_a_last;
    logic w_d_last;
    logic w_expire;

    assign w_rx_hs  = rx_valid & rx_ready;
    assign w_tx_hs  = tx_valid & tx_ready;
    assign w_in_rx  = (r_state == c_ADDR) || (r_state == c_WDATA);
    assign w_a_last = (r_fcnt == c_AF_LAST);
    assign w_d_last = (r_fcnt == c_DF_LAST);
    // A frame arriving in the expiry cycle keeps the command alive.
    assign w_expire = c_TEN && w_in_rx && !w_rx_hs && (r_tcnt == c_TLIM);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_rx_hs) w_next = c_ADDR;
            c_ADDR: begin
                if (w_rx_hs && w_a_last) w_next = r_cmd[0] ? c_WDATA : c_RREQ;
                else if (w_expire)       w_next = c_IDLE;
            end
            c_WDATA: begin
                if (w_rx_hs && w_d_last) w_next = c_WREQ;
                else if (w_expire)       w_next = c_IDLE;
            end
            c_WREQ:  if (mem_gnt) w_next = (r_remain == '0) ? c_ACK : c_WDATA;
            c_ACK:   if (w_tx_hs) w_next = c_IDLE;
            c_RREQ:  if (mem_gnt) w_next = c_RWAIT;
            c_RWAIT: if (mem_rvalid) w_next = c_RSEND;
            c_RSEND: if (w_tx_hs && w_d_last) w_next = (r_remain == '0) ? c_IDLE : c_RREQ;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = (r_state == c_IDLE) || w_in_rx;
        tx_valid = (r_state == c_ACK) || (r_state == c_RSEND);
        mem_req  = (r_state == c_WREQ) || (r_state == c_RREQ);
        mem_we   = (r_state == c_WREQ);
        busy     = (r_state != c_IDLE);
        tx_data  = '0;
        if (r_state == c_ACK)   tx_data = r_cmd;
        if (r_state == c_RSEND) tx_data = r_word[FRAME_WIDTH-1:0];
    end

    assign mem_addr    = r_addr[ADDR_WIDTH-1:0];
    assign mem_wdata   = r_word[DATA_WIDTH-1:0];
    assign err_timeout = r_err;

    // Multi-frame fields shift in from the top so the first (LS) frame lands at bit 0.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cmd    <= '0;
            r_remain <= '0;
            r_addr   <= '0;
            r_word   <= '0;
            r_fcnt   <= '0;
            r_tcnt   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_expire;
            if (!w_in_rx || w_rx_hs || w_expire) r_tcnt <= '0;
            else                                 r_tcnt <= r_tcnt + c_TW'(1);

            case (r_state)
                c_IDLE: begin
                    if (w_rx_hs) begin
                        r_cmd    <= rx_data;
                        r_remain <= rx_data[FRAME_WIDTH-1:1];
                    end
                end
                c_ADDR: begin
                    if (w_rx_hs) begin
                        r_addr <= (r_addr >> FRAME_WIDTH) | (c_AW'(rx_data) << (c_AW - FRAME_WIDTH));
                        r_fcnt <= w_a_last ? '0 : r_fcnt + c_FCW'(1);
                    end else if (w_expire) begin
                        r_fcnt <= '0;
                    end
                end
                c_WDATA: begin
                    if (w_rx_hs) begin
                        r_word <= (r_word >> FRAME_WIDTH) | (c_DW'(rx_data) << (c_DW - FRAME_WIDTH));
                        r_fcnt <= w_d_last ? '0 : r_fcnt + c_FCW'(1);
                    end else if (w_expire) begin
                        r_fcnt <= '0;
                    end
                end
                c_WREQ: begin
                    if (mem_gnt) begin
                        r_addr[ADDR_WIDTH-1:0] <= r_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                        if (r_remain != '0) r_remain <= r_remain - c_LW'(1);
                    end
                end
                c_RWAIT: begin
                    if (mem_rvalid) r_word <= c_DW'(mem_rdata);
                end
                c_RSEND: begin
                    if (w_tx_hs) begin
                        r_word <= r_word >> FRAME_WIDTH;
                        r_fcnt <= w_d_last ? '0 : r_fcnt + c_FCW'(1);
                        if (w_d_last) begin
                            r_addr[ADDR_WIDTH-1:0] <= r_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                            if (r_remain != '0) r_remain <= r_remain - c_LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
